// File: rtl/uart_pkg.sv
// Register map, STATUS/CTRL bit positions and drain-FSM encoding for the
// memory-mapped UART bridge.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_TX_BUSY  = 3;
    localparam int STAT_OVERFLOW = 4;
    localparam int STAT_TX_EN    = 5;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_TX_EN   = 1;

    // A transmitter that never raises busy is assumed done after this many cycles
    localparam int BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        DRAIN_IDLE      = 2'd0,
        DRAIN_LOAD      = 2'd1,
        DRAIN_WAIT_BUSY = 2'd2,
        DRAIN_WAIT_DONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two circular FIFO feeding the transmitter; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_if.sv
// CPU load/store window onto a UART: TX FIFO with drain FSM, RX head read,
// STATUS and CTRL registers.
module uart_bus_if
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [7:0]  uart_tx_data,
    output logic        uart_start,
    input  logic        uart_tx_busy,
    input  logic [31:0] uart_rx_data,
    input  logic        uart_rx_empty,
    output logic        uart_rx_read_en
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          hit;
    logic [1:0]    offset;
    logic          store;
    logic          load;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          overflow;
    logic          tx_en;
    logic          ovf_set;
    logic          ovf_clr;
    logic          ctrl_store;
    logic [31:0]   status;
    logic [31:0]   read_value;
    drain_state_t  state;
    logic [1:0]    wait_cnt;
    logic          unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // A simultaneous store and load is treated as a store only
    assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:2];
    assign store      = we && hit;
    assign load       = re && !we;
    assign tx_push    = store && (offset == OFF_TXDATA);
    assign ctrl_store = store && (offset == OFF_CTRL);
    assign tx_pop     = (state == DRAIN_LOAD);
    assign ovf_set    = tx_push && tx_full && !tx_pop;
    assign ovf_clr    = ctrl_store && wdata[CTRL_CLR_OVF];

    assign uart_rx_read_en = rst && load && hit && (offset == OFF_RXDATA) && !uart_rx_empty;

    uart_tx_fifo #(
        .DEPTH(TX_DEPTH),
        .WIDTH(8)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_data(wdata[7:0]),
        .pop      (tx_pop),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    // Sticky overflow: a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            tx_en    <= 1'b1;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (ctrl_store) begin
                tx_en <= wdata[CTRL_TX_EN];
            end
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_EMPTY] = uart_rx_empty;
        status[STAT_TX_BUSY]  = uart_tx_busy;
        status[STAT_OVERFLOW] = overflow;
        status[STAT_TX_EN]    = tx_en;

        read_value = '0;
        if (hit) begin
            case (offset)
                OFF_RXDATA: if (!uart_rx_empty) read_value = uart_rx_data;
                OFF_STATUS: read_value = status;
                OFF_CTRL:   read_value[CTRL_TX_EN] = tx_en;
                default:    read_value = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= load;
            rdata  <= load ? read_value : '0;
        end
    end

    // uart_start and uart_tx_data are registered together so the transmitter
    // sees the byte in the same cycle as the start pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= DRAIN_IDLE;
            wait_cnt     <= '0;
            uart_start   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            uart_start <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (tx_en && (tx_count != '0) && !uart_tx_busy) begin
                        state <= DRAIN_LOAD;
                    end
                end
                DRAIN_LOAD: begin
                    uart_tx_data <= tx_head;
                    uart_start   <= 1'b1;
                    wait_cnt     <= '0;
                    state        <= DRAIN_WAIT_BUSY;
                end
                DRAIN_WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= DRAIN_WAIT_DONE;
                    end else if (wait_cnt == 2'(BUSY_TIMEOUT - 1)) begin
                        state <= DRAIN_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state <= DRAIN_IDLE;
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_if.sv
// Self-checking bench for uart_bus_if: directed scenarios plus a randomized
// register-access phase checked against a queue-based model of the bridge.
module tb_uart_bus_if;

    localparam logic [31:0] BASE     = 32'h0000_8000;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_RXDATA = BASE + 32'h4;
    localparam logic [31:0] A_STATUS = BASE + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE + 32'hC;
    localparam int          DEPTH    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  uart_tx_data;
    logic        uart_start;
    logic        uart_tx_busy;
    logic [31:0] uart_rx_data;
    logic        uart_rx_empty;
    logic        uart_rx_read_en;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: bytes accepted but not yet started, plus the two control bits
    logic [7:0] exp_tx[$];
    logic       m_overflow;
    logic       m_tx_en;
    int         exp_starts = 0;
    int         start_cnt  = 0;
    int         rx_pops    = 0;
    int         cyc        = 0;
    int         busy_len   = 0;
    int         busy_cnt   = 0;
    int         start_cyc[$];

    always #5 clk = ~clk;

    uart_bus_if #(
        .BASE_ADDR(BASE),
        .TX_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .wdata          (wdata),
        .we             (we),
        .re             (re),
        .rdata          (rdata),
        .rvalid         (rvalid),
        .uart_tx_data   (uart_tx_data),
        .uart_start     (uart_start),
        .uart_tx_busy   (uart_tx_busy),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_empty  (uart_rx_empty),
        .uart_rx_read_en(uart_rx_read_en)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (exp_tx.size() == DEPTH);
        s[1] = (exp_tx.size() == 0);
        s[2] = uart_rx_empty;
        s[3] = uart_tx_busy;
        s[4] = m_overflow;
        s[5] = m_tx_en;
        return s;
    endfunction

    // Transmitter model and start monitor
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (uart_rx_read_en) rx_pops++;
            if (!rst) begin
                uart_tx_busy = 1'b0;
                busy_cnt     = 0;
            end else if (uart_start) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                check_output("start_while_busy", {31'b0, uart_tx_busy}, 32'h0);
                if (exp_tx.size() == 0) begin
                    check_output("tx_unexpected_start", start_cnt, exp_starts);
                end else begin
                    check_output("tx_byte", {24'b0, uart_tx_data}, {24'b0, exp_tx.pop_front()});
                end
                if (busy_len > 0) begin
                    uart_tx_busy = 1'b1;
                    busy_cnt     = busy_len;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) uart_tx_busy = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        re    = 1'b0;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v, output logic pop_seen);
        addr = a;
        re   = 1'b1;
        we   = 1'b0;
        @(negedge clk);
        pop_seen = uart_rx_read_en;
        @(posedge clk);
        #1;
        re = 1'b0;
        d  = rdata;
        v  = rvalid;
    endtask

    task automatic tx_store(input logic [7:0] b, input bit pop_now);
        bus_write(A_TXDATA, {24'h0, b});
        if (exp_tx.size() < DEPTH || pop_now) begin
            exp_tx.push_back(b);
            exp_starts++;
        end else begin
            m_overflow = 1'b1;
        end
    endtask

    task automatic ctrl_store(input logic [31:0] d);
        bus_write(A_CTRL, d);
        if (d[0]) m_overflow = 1'b0;
        m_tx_en = d[1];
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_tx.size() != 0 || uart_tx_busy) && guard < 2000) begin
            idle(1);
            guard++;
        end
        idle(8);
        check_output({tag, "_left"}, exp_tx.size(), 0);
        check_output({tag, "_starts"}, start_cnt, exp_starts);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic        p;
        int          pops0;
        int          base_idx;
        int          guard;

        addr          = '0;
        wdata         = '0;
        we            = 1'b0;
        re            = 1'b0;
        uart_rx_data  = '0;
        uart_rx_empty = 1'b1;
        m_overflow    = 1'b0;
        m_tx_en       = 1'b1;

        #2 rst = 1'b0;
        idle(3);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check_output("rst_start", {31'b0, uart_start}, 32'h0);
        check_output("rst_rx_read_en", {31'b0, uart_rx_read_en}, 32'h0);
        check_output("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        rst = 1'b1;
        idle(2);

        bus_read(A_STATUS, d, v, p);
        check_output("status_after_rst", d, model_status());
        bus_read(A_CTRL, d, v, p);
        check_output("ctrl_after_rst", d, {30'b0, m_tx_en, 1'b0});

        // Three bytes through a transmitter that is busy for 10 cycles each
        $display("[TB] sequence 41/42/43 with busy transmitter");
        busy_len = 10;
        tx_store(8'h41, 1'b0);
        tx_store(8'h42, 1'b0);
        tx_store(8'h43, 1'b0);
        wait_drain("abc");

        // Overfill with tx disabled, then clear overflow
        $display("[TB] overflow with tx disabled");
        uart_rx_empty = 1'b0;
        uart_rx_data  = $urandom;
        ctrl_store(32'h0);
        for (int i = 0; i < 9; i++) tx_store(8'($urandom), 1'b0);
        bus_read(A_STATUS, d, v, p);
        check_output("status_overflow", d, model_status());
        bus_read(A_CTRL, d, v, p);
        check_output("ctrl_disabled", d, {30'b0, m_tx_en, 1'b0});
        busy_len = 2;
        ctrl_store(32'h3);
        bus_read(A_STATUS, d, v, p);
        check_output("status_ovf_cleared", d & 32'h30, {26'b0, m_tx_en, m_overflow, 4'b0});
        wait_drain("fill9");

        // RX head reads
        $display("[TB] rx reads");
        uart_rx_data  = 32'h0000_005A;
        uart_rx_empty = 1'b0;
        pops0 = rx_pops;
        bus_read(A_RXDATA, d, v, p);
        check_output("rx_valid", {31'b0, v}, 32'h1);
        check_output("rx_data", d, 32'h5A);
        check_output("rx_pop_in_re_cycle", {31'b0, p}, 32'h1);
        idle(1);
        check_output("rx_rvalid_pulse", {31'b0, rvalid}, 32'h0);
        check_output("rx_pop_count", rx_pops - pops0, 1);
        uart_rx_empty = 1'b1;
        pops0 = rx_pops;
        bus_read(A_RXDATA, d, v, p);
        check_output("rx_empty_data", d, 32'h0);
        check_output("rx_empty_valid", {31'b0, v}, 32'h1);
        idle(1);
        check_output("rx_empty_no_pop", rx_pops - pops0, 0);

        bus_read(32'h0000_9004, d, v, p);
        check_output("miss_valid", {31'b0, v}, 32'h1);
        check_output("miss_data", d, 32'h0);

        addr  = A_CTRL;
        wdata = 32'h2;
        we    = 1'b1;
        re    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
        check_output("we_re_store_only", {31'b0, rvalid}, 32'h0);

        // Transmitter that never raises busy: fall back after the timeout
        $display("[TB] busy never asserted");
        busy_len = 0;
        base_idx = start_cyc.size();
        tx_store(8'h11, 1'b0);
        tx_store(8'h22, 1'b0);
        wait_drain("nobusy");
        if (start_cyc.size() >= base_idx + 2) begin
            check_output("nobusy_gap", start_cyc[base_idx+1] - start_cyc[base_idx], 6);
        end else begin
            check_output("nobusy_start_count", start_cyc.size() - base_idx, 2);
        end

        // Reset in the middle of a byte with more queued
        $display("[TB] reset during transfer");
        busy_len = 10;
        tx_store(8'hA5, 1'b0);
        tx_store(8'hB6, 1'b0);
        tx_store(8'hC7, 1'b0);
        tx_store(8'hD8, 1'b0);
        guard = 0;
        while (!uart_tx_busy && guard < 100) begin
            idle(1);
            guard++;
        end
        check_output("busy_seen", {31'b0, uart_tx_busy}, 32'h1);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_rdata", rdata, 32'h0);
        check_output("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        check_output("midrst_start", {31'b0, uart_start}, 32'h0);
        check_output("midrst_rx_read_en", {31'b0, uart_rx_read_en}, 32'h0);
        check_output("midrst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        exp_starts -= exp_tx.size();
        exp_tx.delete();
        m_overflow = 1'b0;
        m_tx_en    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        bus_read(A_STATUS, d, v, p);
        check_output("status_after_midrst", d, model_status());
        idle(20);
        check_output("starts_after_midrst", start_cnt, exp_starts);

        // Store into a full FIFO in the same cycle the drain pops
        $display("[TB] full FIFO store coinciding with pop");
        busy_len = 3;
        ctrl_store(32'h0);
        for (int i = 0; i < DEPTH; i++) tx_store(8'(8'h60 + i), 1'b0);
        bus_read(A_STATUS, d, v, p);
        check_output("status_full", d, model_status());
        ctrl_store(32'h2);
        idle(1);
        tx_store(8'h99, 1'b1);
        bus_read(A_STATUS, d, v, p);
        check_output("ovf_after_pop_store", {31'b0, d[4]}, {31'b0, m_overflow});
        wait_drain("popstore");

        // Randomized register traffic with the drain disabled
        $display("[TB] random register traffic");
        ctrl_store(32'h0);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0, 1: tx_store(8'($urandom), 1'b0);
                2: begin
                    bus_read(A_STATUS, d, v, p);
                    check_output("rnd_status", d, model_status());
                end
                3: begin
                    bus_read(A_CTRL, d, v, p);
                    check_output("rnd_ctrl", d, {30'b0, m_tx_en, 1'b0});
                end
                4: ctrl_store($urandom & 32'hFFFF_FFFD);
                5: begin
                    uart_rx_empty = 1'($urandom_range(0, 1));
                    uart_rx_data  = $urandom;
                    bus_read(A_RXDATA, d, v, p);
                    check_output("rnd_rx_data", d, uart_rx_empty ? 32'h0 : uart_rx_data);
                    check_output("rnd_rx_pop", {31'b0, p}, {31'b0, !uart_rx_empty});
                end
                6: begin
                    logic [31:0] ma;
                    ma = $urandom;
                    if (ma[31:4] == BASE[31:4]) ma = ma ^ 32'h1000_0000;
                    bus_read(ma, d, v, p);
                    check_output("rnd_miss", {d[30:0], v}, 32'h1);
                end
                default: begin
                    bus_read(A_TXDATA, d, v, p);
                    check_output("rnd_txdata_read", d, 32'h0);
                end
            endcase
        end
        uart_rx_empty = 1'b1;
        ctrl_store(32'h2);
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
